// File: rtl/alu_exec_unit.sv
// ALU execute stage: ALUOp/func decode, registered single-cycle results, and an
// iterative unsigned multiply/divide engine writing HI/LO, with valid/ready on both sides.
module alu_exec_unit #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          MULDIV_EN = 1'b1,
  localparam int unsigned SHAMT_W  = $clog2(WIDTH)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [2:0]         i_alu_op,
  input  logic [5:0]         i_func,
  input  logic [SHAMT_W-1:0] i_shamt,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [WIDTH-1:0]   o_result,
  output logic               o_zero,
  output logic               o_illegal,
  output logic               o_busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_OR    = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_SLT   = 4'd4;
  localparam logic [3:0] OP_NOR   = 4'd5;
  localparam logic [3:0] OP_SLL   = 4'd6;
  localparam logic [3:0] OP_SRL   = 4'd7;
  localparam logic [3:0] OP_MFHI  = 4'd8;
  localparam logic [3:0] OP_MFLO  = 4'd9;
  localparam logic [3:0] OP_MULTU = 4'd10;
  localparam logic [3:0] OP_DIVU  = 4'd11;

  logic [1:0]         r_state;
  logic [SHAMT_W-1:0] r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;
  logic               r_illegal;

  logic [3:0]         w_op;
  logic               w_ill;
  logic               w_is_md;
  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_alu;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_div_trial;
  logic [WIDTH:0]     w_div_diff;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_md_next;

  always_comb begin
    w_op  = OP_ADD;
    w_ill = 1'b0;
    case (i_alu_op)
      3'b000: w_op = OP_ADD;
      3'b010: w_op = OP_SUB;
      3'b011: w_op = OP_OR;
      3'b100: w_op = OP_AND;
      3'b101: w_op = OP_SLT;
      3'b001: begin
        case (i_func)
          6'd32: w_op = OP_ADD;
          6'd34: w_op = OP_SUB;
          6'd37: w_op = OP_OR;
          6'd36: w_op = OP_AND;
          6'd42: w_op = OP_SLT;
          6'd39: w_op = OP_NOR;
          6'd0:  w_op = OP_SLL;
          6'd2:  w_op = OP_SRL;
          6'd25: begin w_op = OP_MULTU; w_ill = !MULDIV_EN; end
          6'd27: begin w_op = OP_DIVU;  w_ill = !MULDIV_EN; end
          6'd16: begin w_op = OP_MFHI;  w_ill = !MULDIV_EN; end
          6'd18: begin w_op = OP_MFLO;  w_ill = !MULDIV_EN; end
          default: w_ill = 1'b1;
        endcase
      end
      default: w_ill = 1'b1;
    endcase
  end

  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD:  w_alu = i_a + i_b;
      OP_SUB:  w_alu = i_a - i_b;
      OP_OR:   w_alu = i_a | i_b;
      OP_AND:  w_alu = i_a & i_b;
      OP_NOR:  w_alu = ~(i_a | i_b);
      OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      OP_SLL:  w_alu = i_b << i_shamt;
      OP_SRL:  w_alu = i_b >> i_shamt;
      OP_MFHI: w_alu = r_hi;
      OP_MFLO: w_alu = r_lo;
      default: w_alu = '0;
    endcase
  end

  assign w_is_md    = !w_ill && ((w_op == OP_MULTU) || (w_op == OP_DIVU));
  assign o_in_ready = (r_state == ST_IDLE) && (!r_out_valid || i_out_ready);
  assign w_accept   = i_in_valid && o_in_ready;
  assign w_last     = (r_cnt == SHAMT_W'(WIDTH - 1));

  // Multiply: multiplier sits in the low half and shifts out as the product shifts in.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
  assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};

  // Divide: {remainder, dividend/quotient}; a zero divisor yields all-ones quotient, rem = a.
  assign w_div_trial = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_diff  = w_div_trial - {1'b0, r_opnd};
  assign w_div_next  = !w_div_diff[WIDTH] ? {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1}
                                          : {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

  assign w_md_next = (r_state == ST_MUL) ? w_mul_next : w_div_next;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_opnd      <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b1;
      r_illegal   <= 1'b0;
    end else if (w_accept) begin
      if (w_is_md) begin
        r_state     <= (w_op == OP_MULTU) ? ST_MUL : ST_DIV;
        r_cnt       <= '0;
        r_acc       <= {{WIDTH{1'b0}}, ((w_op == OP_MULTU) ? i_b : i_a)};
        r_opnd      <= (w_op == OP_MULTU) ? i_a : i_b;
        r_out_valid <= 1'b0;
        r_illegal   <= 1'b0;
      end else begin
        r_out_valid <= 1'b1;
        r_result    <= w_ill ? '0 : w_alu;
        r_zero      <= w_ill || (w_alu == '0);
        r_illegal   <= w_ill;
      end
    end else if (r_state != ST_IDLE) begin
      r_acc <= w_md_next;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_state     <= ST_IDLE;
        r_hi        <= w_md_next[2*WIDTH-1:WIDTH];
        r_lo        <= w_md_next[WIDTH-1:0];
        r_out_valid <= 1'b1;
        r_result    <= w_md_next[WIDTH-1:0];
        r_zero      <= (w_md_next[WIDTH-1:0] == '0);
        r_illegal   <= 1'b0;
      end
    end else if (i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_result    = r_result;
  assign o_zero      = r_zero;
  assign o_illegal   = r_illegal;
  assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed ops push expected results, a monitor
// pops and compares whenever the unit presents a result.
module tb_alu_exec_unit;

  localparam logic [5:0] F_ADD = 6'd32, F_SUB = 6'd34, F_SLT = 6'd42, F_NOR = 6'd39;
  localparam logic [5:0] F_SLL = 6'd0, F_SRL = 6'd2, F_MULTU = 6'd25, F_DIVU = 6'd27;
  localparam logic [5:0] F_MFHI = 6'd16, F_MFLO = 6'd18;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  alu_op;
  logic [5:0]  func;
  logic [4:0]  shamt;
  logic [31:0] a, b, result;
  logic        zero, illegal, busy;

  logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  logic [31:0] n_result;
  logic        n_zero, n_illegal, n_busy;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   mon_seen = 1'b0;

  alu_exec_unit #(.WIDTH(32), .MULDIV_EN(1'b1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_alu_op(alu_op), .i_func(func), .i_shamt(shamt), .i_a(a), .i_b(b),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_result(result),
    .o_zero(zero), .o_illegal(illegal), .o_busy(busy)
  );

  alu_exec_unit #(.WIDTH(32), .MULDIV_EN(1'b0)) u_dut_nomd (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(n_in_valid), .o_in_ready(n_in_ready),
    .i_alu_op(alu_op), .i_func(func), .i_shamt(shamt), .i_a(a), .i_b(b),
    .o_out_valid(n_out_valid), .i_out_ready(n_out_ready), .o_result(n_result),
    .o_zero(n_zero), .o_illegal(n_illegal), .o_busy(n_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] er, input logic ei, input int lat);
    int n = 0;
    alu_op = op; func = fn; shamt = sh; a = va; b = vb; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: in_ready still 0 after %0d cycles, expected 1", n);
    end else begin
      sb.push_back('{er, ei, cyc + lat});
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic rop(input logic [5:0] fn, input logic [31:0] va, input logic [31:0] vb,
                     input logic [4:0] sh, input logic [31:0] er);
    issue(3'b001, fn, sh, va, vb, er, 1'b0, (fn == F_MULTU || fn == F_DIVU) ? 33 : 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: %0d results still pending, expected 0", sb.size());
    end
  endtask

  task automatic nomd_op(input logic [5:0] fn, input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] er, input logic ei);
    alu_op = 3'b001; func = fn; shamt = 5'd0; a = va; b = vb; n_in_valid = 1'b1;
    #1;
    chk("nomd_in_ready", n_in_ready, 1);
    @(negedge clk);
    n_in_valid = 1'b0;
    chk("nomd_out_valid", n_out_valid, 1);
    chk("nomd_result", n_result, er);
    chk("nomd_zero", n_zero, er == 0);
    chk("nomd_illegal", n_illegal, ei);
    chk("nomd_busy", n_busy, 0);
  endtask

  // Monitor: compare the head entry every cycle a result is presented (also covers stability).
  initial begin
    forever begin
      @(negedge clk); #2;
      if (rst_n && out_valid) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_output: got result 0x%08h, expected no output", result);
        end else begin
          if (!mon_seen) begin
            chk("latency", cyc, sb[0].cyc);
            mon_seen = 1'b1;
          end
          chk("result", result, sb[0].res);
          chk("zero", zero, sb[0].res == 0);
          chk("illegal", illegal, sb[0].ill);
          if (out_ready) begin
            void'(sb.pop_front());
            mon_seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int n;
    rst_n = 1'b0; in_valid = 1'b0; n_in_valid = 1'b0; out_ready = 1'b1; n_out_ready = 1'b1;
    alu_op = 3'b000; func = 6'd0; shamt = 5'd0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 1);
    chk("rst_illegal", illegal, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Direct alu_op encodings
    issue(3'b000, 6'd0, 5'd0, 32'd3, 32'd4, 32'd7, 1'b0, 1);
    issue(3'b010, 6'd0, 5'd0, 32'd3, 32'd4, 32'hFFFF_FFFF, 1'b0, 1);
    issue(3'b011, 6'd0, 5'd0, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1);
    issue(3'b100, 6'd0, 5'd0, 32'hFF, 32'h3C, 32'h3C, 1'b0, 1);
    issue(3'b101, 6'd0, 5'd0, 32'd5, 32'hFFFF_FFFD, 32'd0, 1'b0, 1);
    issue(3'b000, 6'd0, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1);

    // Back-to-back R-type, one per clock
    t0 = cyc;
    rop(F_ADD, 32'd5, 32'd7, 5'd0, 32'd12);
    rop(F_SUB, 32'd5, 32'd7, 5'd0, 32'hFFFF_FFFE);
    rop(F_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1);
    rop(F_NOR, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF);
    rop(F_SLL, 32'd0, 32'd1, 5'd31, 32'h8000_0000);
    rop(F_SRL, 32'd0, 32'h8000_0000, 5'd4, 32'h0800_0000);
    chk("b2b_cycles", cyc - t0, 6);

    // multu with busy window
    drain();
    rop(F_MULTU, 32'hFFFF_FFFF, 32'd2, 5'd0, 32'hFFFF_FFFE);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("mul_busy_cycles", n, 32);
    rop(F_MFHI, 32'd0, 32'd0, 5'd0, 32'd1);
    rop(F_MFLO, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFE);

    // divu; the following mfhi stalls until completion and sees the new HI
    rop(F_DIVU, 32'd100, 32'd7, 5'd0, 32'd14);
    rop(F_MFHI, 32'd0, 32'd0, 5'd0, 32'd2);
    rop(F_DIVU, 32'd9, 32'd0, 5'd0, 32'hFFFF_FFFF);
    rop(F_MFHI, 32'd0, 32'd0, 5'd0, 32'd9);

    // Illegal ops leave HI/LO untouched
    issue(3'b111, 6'd0, 5'd0, 32'd1, 32'd2, 32'd0, 1'b1, 1);
    issue(3'b110, 6'd0, 5'd0, 32'd1, 32'd2, 32'd0, 1'b1, 1);
    issue(3'b001, 6'd63, 5'd0, 32'd1, 32'd2, 32'd0, 1'b1, 1);
    rop(F_MFHI, 32'd0, 32'd0, 5'd0, 32'd9);
    rop(F_MFLO, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF);
    drain();

    // MULDIV_EN=0 instance
    nomd_op(F_MULTU, 32'd5, 32'd3, 32'd0, 1'b1);
    nomd_op(F_MFHI, 32'd0, 32'd0, 32'd0, 1'b1);
    nomd_op(F_ADD, 32'd3, 32'd4, 32'd7, 1'b0);

    // Output backpressure: hold out_ready low 3 cycles with a second op waiting
    out_ready = 1'b0;
    issue(3'b000, 6'd0, 5'd0, 32'd1, 32'd2, 32'd3, 1'b0, 1);
    fork
      issue(3'b010, 6'd0, 5'd0, 32'd10, 32'd3, 32'd7, 1'b0, 1);
      begin
        for (int i = 0; i < 3; i++) begin
          #1;
          chk("stall_in_ready", in_ready, 0);
          chk("stall_out_valid", out_valid, 1);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset in the middle of a divide
    rop(F_DIVU, 32'd100, 32'd7, 5'd0, 32'd14);
    repeat (5) @(negedge clk);
    #3;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result", result, 0);
    chk("midrst_zero", zero, 1);
    chk("midrst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rop(F_MFHI, 32'd0, 32'd0, 5'd0, 32'd0);
    rop(F_MFLO, 32'd0, 32'd0, 5'd0, 32'd0);
    drain();
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised successor to the combinational ALU-control decoder.
- Merges ALUOp/func decode with a registered execute stage. Adds an unsigned multi-cycle multiply/divide engine, HI/LO registers, illegal-op flagging and valid/ready handshakes on both sides.
- Sits between decode/register-read and writeback in the multi-cycle datapath.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4, power of 2).
- MULDIV_EN, 1, 1 = multu/divu/mfhi/mflo supported; 0 = those funcs flag illegal.
- SHAMT_W (localparam), $clog2(WIDTH), shift-amount width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  unit accepts operation this cycle.
- alu_op  in  3  000 add, 010 sub, 001 R-type (use func), 011 or, 100 and, 101 slt; 110/111 illegal.
- func  in  6  R-type function: 32 add, 34 sub, 37 or, 36 and, 42 slt, 39 nor, 0 sll, 2 srl, 25 multu, 27 divu, 16 mfhi, 18 mflo; all others illegal.
- shamt  in  SHAMT_W  shift amount for sll/srl.
- a, b  in  WIDTH  operands (sll/srl shift b).
- out_valid  out  1  result held valid.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  operation result.
- zero  out  1  result == 0.
- illegal  out  1  accepted op was undecodable.
- busy  out  1  multiply/divide in progress.

Behaviour:
- Reset (async, rst_n low): state IDLE; out_valid=0, result=0, zero=1, illegal=0, busy=0, HI=LO=0, iteration counter=0. Reset mid-mul/div aborts the operation; HI/LO are not updated.
- Handshake: transfer occurs when in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready), so back-to-back 1-cycle ops sustain one per clock. Output holds result/zero/illegal stable while out_valid && !out_ready.
- Single-cycle ops (add, sub, or, and, nor, sll, srl, slt, mfhi, mflo):
  - Result registered; out_valid rises the cycle after acceptance (latency 1).
  - add/sub wrap modulo 2^WIDTH. slt is signed compare; result is 1 or 0, zero-extended.
  - mfhi/mflo return HI/LO as they stand at acceptance.
- Illegal op: accepted normally. One cycle later out_valid=1, result=0, zero=1, illegal=1. HI/LO untouched.
- State machine: IDLE -> MUL on multu, IDLE -> DIV on divu; MUL/DIV -> IDLE after WIDTH iterations.
- MUL: radix-2 shift-add, one bit per cycle, WIDTH cycles. Product is 2*WIDTH bits; HI=upper, LO=lower.
- DIV: restoring, one bit per cycle, WIDTH cycles; LO=quotient, HI=remainder. Divide by zero: LO=all ones, HI=a, still WIDTH cycles.
- Mul/div completion:
  - Latency from acceptance to out_valid is WIDTH+1 cycles; busy=1 throughout MUL/DIV.
  - Same edge: HI/LO written, state->IDLE, out_valid=1, result=LO. zero reflects LO only.
  - in_ready stays low through MUL/DIV; ops presented meanwhile are stalled, not dropped.
- An mfhi/mflo accepted the cycle after completion sees the new HI/LO.
- zero and illegal register alongside result and are valid only while out_valid=1.

Test Plan:
- Reset asserted mid-stream, then released -> out_valid=0, result=0, zero=1, busy=0; subsequent mfhi returns 0.
- WIDTH=32, back-to-back alu_op=001 ops with out_ready=1: add 5+7, sub 5-7, slt -1<1, nor 0,0, sll b=1 shamt=31 -> results 12, 0xFFFFFFFE, 1, 0xFFFFFFFF, 0x80000000 on consecutive cycles, one per clock.
- multu a=0xFFFFFFFF b=2 -> busy 32 cycles, out_valid at cycle 33, result=LO=0xFFFFFFFE; then mfhi -> 1.
- divu a=100 b=7 -> LO=14, HI=2; divu a=9 b=0 -> LO=0xFFFFFFFF, HI=9, same latency.
- out_ready held 0 for 3 cycles with a result pending -> result/out_valid stable, in_ready=0, new op stalled; released -> single transfer, no loss or duplication.
- alu_op=111, then alu_op=001 func=63, then MULDIV_EN=0 with multu -> each gives illegal=1, result=0, zero=1 after 1 cycle; HI/LO unchanged.
